// File: rtl/ex_multicycle_ctrl.sv
// ----------------------------------------------------------------------------
// ex_multicycle_ctrl
//
// Sequences the multi-cycle EX-stage operations of the 5-stage pipeline:
// two-cycle MADD/MADDU/MSUB/MSUBU and iterative DIV/DIVU. It produces the
// pipeline stall vector and merges in the decode-stage load-use stall. It also
// drives the divider start/annul handshake and holds the 64-bit intermediate
// product and divide result between cycles.
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   ex_op_class_i     EX class: 00 single-cycle/bubble, 01 madd/msub,
//                     10 signed div, 11 unsigned div
//   id_stallreq_i     load-use stall request from ID
//   flush_i           abort any in-flight multi-cycle operation
//   ex_hilo_temp_i/o  product from the first madd cycle / latched copy
//   ex_cnt_o          madd cycle index seen by EX (0 first, 1 second)
//   div_start_o       divider start / keep-busy request (combinational)
//   div_signed_o      divide signedness, captured when the divide starts
//   div_annul_o       one-cycle divider cancel pulse (combinational)
//   div_ready_i       divider result valid pulse
//   div_result_i      {remainder, quotient} from the divider
//   ex_div_result_o   latched divide result (zero after a watchdog abort)
//   ex_div_done_o     EX may consume ex_div_result_o this cycle
//   div_timeout_o     sticky watchdog flag, cleared only by rst
//   stall_o           [0]PC [1]IF [2]ID [3]EX [4]MEM [5]WB hold bits
//                     (combinational)
// ----------------------------------------------------------------------------
module ex_multicycle_ctrl #(
  parameter int DIV_MAX_CYCLES = 40
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  ex_op_class_i,
  input  logic        id_stallreq_i,
  input  logic        flush_i,
  input  logic [63:0] ex_hilo_temp_i,
  output logic [63:0] ex_hilo_temp_o,
  output logic [1:0]  ex_cnt_o,
  output logic        div_start_o,
  output logic        div_signed_o,
  output logic        div_annul_o,
  input  logic        div_ready_i,
  input  logic [63:0] div_result_i,
  output logic [63:0] ex_div_result_o,
  output logic        ex_div_done_o,
  output logic        div_timeout_o,
  output logic [5:0]  stall_o
);

  localparam int WD_W = $clog2(DIV_MAX_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MADD2    = 2'd1,
    DIV_WAIT = 2'd2,
    DIV_DONE = 2'd3
  } state_t;

  state_t          state, state_nxt;
  logic [WD_W-1:0] wd_cnt, wd_cnt_nxt;
  logic [63:0]     hilo_nxt, div_result_nxt;
  logic [1:0]      cnt_nxt;
  logic            done_nxt, signed_nxt, timeout_nxt;
  logic            ex_stall;

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      wd_cnt          <= '0;
      ex_hilo_temp_o  <= '0;
      ex_div_result_o <= '0;
      ex_cnt_o        <= '0;
      ex_div_done_o   <= 1'b0;
      div_signed_o    <= 1'b0;
      div_timeout_o   <= 1'b0;
    end else begin
      state           <= state_nxt;
      wd_cnt          <= wd_cnt_nxt;
      ex_hilo_temp_o  <= hilo_nxt;
      ex_div_result_o <= div_result_nxt;
      ex_cnt_o        <= cnt_nxt;
      ex_div_done_o   <= done_nxt;
      div_signed_o    <= signed_nxt;
      div_timeout_o   <= timeout_nxt;
    end
  end

  // Next state, next register values and combinational handshake/stall
  always_comb begin
    state_nxt      = state;
    wd_cnt_nxt     = wd_cnt;
    hilo_nxt       = ex_hilo_temp_o;
    div_result_nxt = ex_div_result_o;
    cnt_nxt        = ex_cnt_o;
    done_nxt       = 1'b0;          // done is high only for the DIV_DONE cycle
    signed_nxt     = div_signed_o;
    timeout_nxt    = div_timeout_o;
    ex_stall       = 1'b0;
    div_start_o    = 1'b0;
    div_annul_o    = 1'b0;
    stall_o        = 6'b000000;

    case (state)
      IDLE: begin
        wd_cnt_nxt = '0;
        if (ex_op_class_i == 2'b01) begin
          ex_stall  = 1'b1;
          hilo_nxt  = ex_hilo_temp_i;
          cnt_nxt   = 2'd1;
          state_nxt = MADD2;
        end else if (ex_op_class_i[1]) begin
          ex_stall    = 1'b1;
          div_start_o = 1'b1;
          signed_nxt  = ~ex_op_class_i[0];
          state_nxt   = DIV_WAIT;
        end
      end
      MADD2: begin
        cnt_nxt   = 2'd0;
        state_nxt = IDLE;
      end
      DIV_WAIT: begin
        ex_stall    = 1'b1;
        div_start_o = 1'b1;
        wd_cnt_nxt  = wd_cnt + WD_W'(1);
        // A result arriving on the watchdog cycle is still taken.
        if (div_ready_i) begin
          div_result_nxt = div_result_i;
          done_nxt       = 1'b1;
          state_nxt      = DIV_DONE;
        end else if (wd_cnt == WD_W'(DIV_MAX_CYCLES - 1)) begin
          div_annul_o    = 1'b1;
          timeout_nxt    = 1'b1;
          div_result_nxt = '0;
          done_nxt       = 1'b1;
          state_nxt      = DIV_DONE;
        end
      end
      DIV_DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    // Flush overrides everything the state decode produced this cycle.
    if (flush_i) begin
      state_nxt      = IDLE;
      wd_cnt_nxt     = '0;
      hilo_nxt       = '0;
      cnt_nxt        = 2'd0;
      done_nxt       = 1'b0;
      signed_nxt     = div_signed_o;
      timeout_nxt    = div_timeout_o;
      div_result_nxt = ex_div_result_o;
      ex_stall       = 1'b0;
      div_start_o    = 1'b0;
      div_annul_o    = (state == DIV_WAIT) ||
                       ((state == IDLE) && ex_op_class_i[1]);
    end

    if (flush_i)
      stall_o = 6'b000000;
    else if (ex_stall)
      stall_o = 6'b001111;
    else if (id_stallreq_i)
      stall_o = 6'b000111;

    // The divider shares rst, so no annul is needed while reset is applied.
    if (rst) begin
      div_start_o = 1'b0;
      div_annul_o = 1'b0;
      stall_o     = 6'b000000;
    end
  end

endmodule

// File: tb/tb_ex_multicycle_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ex_multicycle_ctrl
//
// Directed and randomized transactions (idle/load-use, madd, div with a chosen
// ready latency, flushes, resets). Expected outputs for every cycle of each
// transaction are derived from the transaction parameters; the model keeps
// only the architecturally visible held values (product, divide result,
// signedness, sticky timeout).
// ----------------------------------------------------------------------------
module tb_ex_multicycle_ctrl;

  localparam int MAXC = 40;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  cls;
  logic        idreq;
  logic        flush;
  logic [63:0] temp_i;
  logic [63:0] temp_o;
  logic [1:0]  cnt;
  logic        start;
  logic        sgn_o;
  logic        annul;
  logic        ready;
  logic [63:0] result_i;
  logic [63:0] divres;
  logic        done;
  logic        timeout;
  logic [5:0]  stall;

  always #5 clk = ~clk;

  ex_multicycle_ctrl #(.DIV_MAX_CYCLES(MAXC)) dut (
    .clk             (clk),
    .rst             (rst),
    .ex_op_class_i   (cls),
    .id_stallreq_i   (idreq),
    .flush_i         (flush),
    .ex_hilo_temp_i  (temp_i),
    .ex_hilo_temp_o  (temp_o),
    .ex_cnt_o        (cnt),
    .div_start_o     (start),
    .div_signed_o    (sgn_o),
    .div_annul_o     (annul),
    .div_ready_i     (ready),
    .div_result_i    (result_i),
    .ex_div_result_o (divres),
    .ex_div_done_o   (done),
    .div_timeout_o   (timeout),
    .stall_o         (stall)
  );

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;

  // Architecturally held values expected from the DUT.
  logic [63:0] m_hilo    = '0;
  logic [63:0] m_divres  = '0;
  logic        m_timeout = 1'b0;
  logic        m_signed  = 1'b0;

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [5:0] idle_stall(input logic id);
    return id ? 6'b000111 : 6'b000000;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_held(input string pfx);
    chk({pfx, ".hilo"},    temp_o,  m_hilo);
    chk({pfx, ".divres"},  divres,  m_divres);
    chk({pfx, ".timeout"}, timeout, m_timeout);
    chk({pfx, ".signed"},  sgn_o,   m_signed);
  endtask

  // Move 1 time unit past the rising edge; inputs are then applied for the
  // new cycle and outputs sampled 1 unit later.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic [1:0] c, input logic id, input logic f,
                       input logic [63:0] t, input logic rdy, input logic [63:0] res);
    rst = r; cls = c; idreq = id; flush = f; temp_i = t; ready = rdy; result_i = res;
    #1;
  endtask

  task automatic model_reset();
    m_hilo = '0; m_divres = '0; m_timeout = 1'b0; m_signed = 1'b0;
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      cyc();
      drive(1'b1, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0,
            rnd64(), 1'($urandom_range(0, 1)), rnd64());
      chk("rst.stall", stall, 6'b000000);
      chk("rst.start", start, 1'b0);
      chk("rst.annul", annul, 1'b0);
      if (i > 0) begin
        model_reset();
        chk("rst.cnt",  cnt,  2'd0);
        chk("rst.done", done, 1'b0);
        chk_held("rst");
      end
    end
    model_reset();
  endtask

  task automatic do_idle(input logic id);
    cyc();
    drive(1'b0, 2'b00, id, 1'b0, rnd64(), 1'($urandom_range(0, 1)), rnd64());
    chk("idle.stall", stall, idle_stall(id));
    chk("idle.start", start, 1'b0);
    chk("idle.annul", annul, 1'b0);
    chk("idle.cnt",   cnt,   2'd0);
    chk("idle.done",  done,  1'b0);
    chk_held("idle");
  endtask

  task automatic do_madd(input logic [63:0] t, input logic id, input logic rst_b);
    cyc();
    drive(1'b0, 2'b01, id, 1'b0, t, 1'($urandom_range(0, 1)), rnd64());
    chk("madd0.stall", stall, 6'b001111);
    chk("madd0.start", start, 1'b0);
    chk("madd0.annul", annul, 1'b0);
    chk("madd0.cnt",   cnt,   2'd0);
    chk("madd0.done",  done,  1'b0);
    chk_held("madd0");
    m_hilo = t;
    // Second cycle: the class input is don't-care, so randomize it.
    cyc();
    drive(rst_b, 2'($urandom_range(0, 3)), id, 1'b0, rnd64(),
          1'($urandom_range(0, 1)), rnd64());
    chk("madd1.stall", stall, rst_b ? 6'b000000 : idle_stall(id));
    chk("madd1.start", start, 1'b0);
    chk("madd1.annul", annul, 1'b0);
    chk("madd1.cnt",   cnt,   2'd1);
    chk("madd1.done",  done,  1'b0);
    chk_held("madd1");
    if (rst_b) model_reset();
  endtask

  // delay: DIV_WAIT cycle (1-based) carrying div_ready_i, 0 = never.
  // flush_at: DIV_WAIT cycle carrying flush_i, 0 = never.
  task automatic do_div(input logic sg, input int delay, input int flush_at,
                        input logic [63:0] res);
    logic [1:0]  c;
    logic        id;
    logic        flushed;
    logic [63:0] r;
    c = sg ? 2'b10 : 2'b11;
    flushed = 1'b0;
    id = 1'($urandom_range(0, 1));
    cyc();
    drive(1'b0, c, id, 1'b0, rnd64(), 1'($urandom_range(0, 1)), rnd64());
    chk("div0.stall", stall, 6'b001111);
    chk("div0.start", start, 1'b1);
    chk("div0.annul", annul, 1'b0);
    chk("div0.cnt",   cnt,   2'd0);
    chk("div0.done",  done,  1'b0);
    chk_held("div0");
    m_signed = sg;
    for (int k = 1; k <= MAXC; k++) begin
      r  = (k == delay) ? res : rnd64();
      id = 1'($urandom_range(0, 1));
      cyc();
      drive(1'b0, c, id, (k == flush_at), rnd64(), (k == delay), r);
      chk("wait.signed", sgn_o, m_signed);
      chk("wait.done",   done,  1'b0);
      chk("wait.cnt",    cnt,   2'd0);
      if (k == flush_at) begin
        chk("flush.stall", stall, 6'b000000);
        chk("flush.start", start, 1'b0);
        chk("flush.annul", annul, 1'b1);
        m_hilo  = '0;
        flushed = 1'b1;
        break;
      end
      chk("wait.stall", stall, 6'b001111);
      chk("wait.start", start, 1'b1);
      if (k == delay) begin
        chk("ready.annul", annul, 1'b0);
        m_divres = res;
        break;
      end
      chk("wait.annul", annul, (k == MAXC));
      if (k == MAXC) begin
        m_divres  = '0;
        m_timeout = 1'b1;
      end
    end
    id = 1'($urandom_range(0, 1));
    cyc();
    if (flushed) begin
      // Back in IDLE: a late ready must not be taken.
      drive(1'b0, 2'b00, id, 1'b0, rnd64(), 1'b1, rnd64());
      chk("postflush.done",  done,  1'b0);
      chk("postflush.start", start, 1'b0);
      chk("postflush.annul", annul, 1'b0);
      chk("postflush.stall", stall, idle_stall(id));
      chk("postflush.cnt",   cnt,   2'd0);
      chk_held("postflush");
    end else begin
      drive(1'b0, 2'b00, id, 1'b0, rnd64(), 1'($urandom_range(0, 1)), rnd64());
      chk("done.done",  done,  1'b1);
      chk("done.start", start, 1'b0);
      chk("done.annul", annul, 1'b0);
      chk("done.stall", stall, idle_stall(id));
      chk("done.cnt",   cnt,   2'd0);
      chk_held("done");
    end
  endtask

  task automatic do_flush_idle(input logic [1:0] c);
    logic id;
    id = 1'($urandom_range(0, 1));
    cyc();
    drive(1'b0, c, id, 1'b1, rnd64(), 1'($urandom_range(0, 1)), rnd64());
    chk("fidle.stall", stall, 6'b000000);
    chk("fidle.start", start, 1'b0);
    chk("fidle.annul", annul, c[1]);
    chk("fidle.cnt",   cnt,   2'd0);
    chk("fidle.done",  done,  1'b0);
    chk_held("fidle");
    m_hilo = '0;
  endtask

  initial begin
    int kind;
    int dly;
    rst = 1'b1; cls = 2'b00; idreq = 1'b0; flush = 1'b0;
    temp_i = '0; ready = 1'b0; result_i = '0;

    do_reset(3);

    // madd with the reference product, then back to IDLE
    do_madd(64'h1_0000_0002, 1'b0, 1'b0);
    do_idle(1'b0);

    // signed divide, ready in the 33rd wait cycle
    do_div(1'b1, 33, 0, 64'h3_0000_0007);
    do_idle(1'b0);

    // load-use alone, and merged with an EX stall
    do_idle(1'b1);
    do_madd(rnd64(), 1'b1, 1'b0);

    // watchdog expiry on an unsigned divide; the flag must stay set
    do_div(1'b0, 0, 0, rnd64());
    do_idle(1'b0);

    // ready on the watchdog cycle wins
    do_div(1'b1, MAXC, 0, rnd64());

    // flush in wait cycle 5, late ready afterwards
    do_div(1'b1, 33, 5, rnd64());

    // flush in IDLE while a divide or madd is being presented
    do_flush_idle(2'b10);
    do_flush_idle(2'b01);
    do_flush_idle(2'b11);

    // reset during the second madd cycle
    do_madd(rnd64(), 1'b0, 1'b1);
    do_idle(1'b0);

    // randomized mix
    for (int i = 0; i < 30; i++) begin
      kind = $urandom_range(0, 5);
      dly  = $urandom_range(1, MAXC + 5);
      case (kind)
        0: do_idle(1'($urandom_range(0, 1)));
        1: do_madd(rnd64(), 1'($urandom_range(0, 1)), 1'b0);
        2: do_div(1'($urandom_range(0, 1)), dly, 0, rnd64());
        3: do_div(1'($urandom_range(0, 1)), dly, $urandom_range(1, MAXC), rnd64());
        4: do_flush_idle(2'($urandom_range(0, 3)));
        default: do_reset(2);
      endcase
    end
    do_idle(1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
